reed_conditioner: RTL and testbench
===================================

# reed_conditioner

Front end of the bike-computer datapath. It conditions the raw reed-switch contact into the clean one-cycle `reed` strobe that the distance and speed counters consume. The raw input is synchronised into the clock domain and debounced. One strobe is emitted per accepted switch closure. The block also provides a debounced level, a saturating count of rejected bounces and a `moving` status flag that drops after a programmable stall time.

## Interface
- `DEBOUNCE_CYCLES`, default 8: consecutive synchronised cycles of a new level required before it is accepted; legal range 1..255.
- `STALL_CYCLES`, default 3000: clock cycles without an accepted closure after which `moving` clears; legal range 2..65535.
- `clock` input 1: single clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-low; all registers take their reset values on any rising edge of `clock` at which `reset == 0`.
- `reed_raw` input 1: asynchronous, bouncy reed-switch contact, 1 = closed.
- `reed` output 1: single-cycle strobe per accepted closure (0→1 of debounced level); reset 0.
- `reed_level` output 1: debounced switch level; reset 0.
- `moving` output 1: 1 while closures arrive faster than `STALL_CYCLES`; reset 0.
- `glitch_count` output 8: rejected-bounce counter, saturates at 255; reset 0.

## Operation
- **Synchroniser:** two flops, `s1 <= reed_raw`, `s2 <= s1`; both reset to 0. Nothing downstream samples `reed_raw` directly.
- **Debounce counter:** `cnt` has width `$clog2(DEBOUNCE_CYCLES+1)` and resets to 0. On each edge:
  - If `s2 == reed_level` and `cnt != 0`, then `cnt <= 0` and `glitch_count` increments, saturating at 255.
  - If `s2 == reed_level` and `cnt == 0`, nothing changes.
  - If `s2 != reed_level` and `cnt == DEBOUNCE_CYCLES-1`, then `reed_level <= s2` and `cnt <= 0`.
  - If `s2 != reed_level` otherwise, `cnt <= cnt+1`.
- **Strobe:**
  - `reed` is registered: it is 1 for exactly the cycle in which `reed_level` first reads 1, and 0 in every other cycle.
  - A release (1→0 acceptance) is debounced identically but produces no strobe.
- **Stall timer:** `stall` has width `$clog2(STALL_CYCLES)` and resets to 0. On each edge:
  - On an accepted closure, `stall <= 0` and `moving <= 1`.
  - Otherwise, if `moving == 1` and `stall == STALL_CYCLES-1`, then `moving <= 0` and `stall <= 0`.
  - Otherwise, if `moving == 1`, `stall <= stall+1`.
  - If `moving == 0`, `stall` holds 0.
- **Simultaneous events:** an accepted closure on the same edge as timeout expiry wins; `moving` stays 1 and `stall` returns to 0.
- **Reset mid-operation:** every register returns to 0 on that edge, including a half-counted debounce and a running stall timer. After release, a raw level already held high must re-qualify the full `DEBOUNCE_CYCLES+2` latency before `reed` fires.

## Timing
- **Closure latency:** `reed_raw` first sampled high at edge k and held high. Then `reed_level` and `reed` rise after edge k+`DEBOUNCE_CYCLES`+1, i.e. `DEBOUNCE_CYCLES+2` edges after sampling. With defaults this is 10 cycles.
- **Release latency:** `reed_level` falls after the same number of edges; there is no strobe.
- **Bounce rejection:** any raw pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles is rejected. It leaves `reed_level` unchanged and adds exactly 1 to `glitch_count`.
- **Strobe spacing:** two strobes are separated by at least `2*DEBOUNCE_CYCLES` cycles, since a release must also be accepted in between.
- **Stall timing:** `moving` falls exactly `STALL_CYCLES` edges after the edge that raised the last `reed` strobe.
- **Combinational paths:** all outputs are registered; there is no combinational path from input to output.

## Test plan
- **Reset:** hold `reset=0` for 3 cycles with `reed_raw=1`. All outputs must read 0. Release reset with the input still high: `reed` pulses once, 10 edges later (defaults).
- **Clean closure:** `DEBOUNCE_CYCLES=8`; raise `reed_raw` and hold it high for 20 cycles. `reed` must be 1 for exactly one cycle at edge k+9, and `reed_level` must be 1 from then on. Then drop `reed_raw`: `reed_level` returns to 0 ten edges later with no strobe.
- **Bounce burst:** apply 3 raw high pulses of 4 cycles each, separated by 4 low cycles, then hold high. `glitch_count` must read 3, and exactly one `reed` strobe must follow the stable hold.
- **Stall timeout:** `STALL_CYCLES=20`; give one clean closure. `moving` must be 1 from the strobe cycle and fall exactly 20 edges later. Apply a second closure whose strobe lands on the expiry edge: `moving` must stay 1.
- **Saturation:** apply 300 short glitches. `glitch_count` must stick at 255 and `reed` must never assert.
- **Reset mid-debounce:** assert `reset` when `cnt`=5 with the input high. After release, the full 10-edge latency must apply again, with no early strobe.

Source files
------------

// File: rtl/reed_conditioner.sv
// Reed-switch front end: synchronise, debounce, one strobe per closure, glitch count, stall flag.
// Latency DEBOUNCE_CYCLES+2 edges raw-to-strobe; no backpressure, the strobe is fire-and-forget.
module reed_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STALL_CYCLES    = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reed_raw,
  output logic       reed,
  output logic       reed_level,
  output logic       moving,
  output logic [7:0] glitch_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          level_q, level_d;
  logic          reed_q, reed_d;
  logic          moving_q, moving_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [7:0]    glitch_q, glitch_d;
  logic          closure;

  always_comb begin
    s1_d     = reed_raw;
    s2_d     = s1_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    closure  = 1'b0;

    if (s2_q == level_q) begin
      // Input fell back before qualifying: that run was a bounce.
      if (cnt_q != '0) begin
        cnt_d = '0;
        if (glitch_q != 8'd255) glitch_d = glitch_q + 8'd1;
      end
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
      closure = s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    reed_d = closure;

    // A closure on the expiry edge takes priority and keeps moving asserted.
    moving_d = moving_q;
    stall_d  = '0;
    if (closure) begin
      moving_d = 1'b1;
    end else if (moving_q) begin
      if (stall_q == STALL_LAST) moving_d = 1'b0;
      else                       stall_d  = stall_q + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      level_q  <= 1'b0;
      reed_q   <= 1'b0;
      moving_q <= 1'b0;
      cnt_q    <= '0;
      stall_q  <= '0;
      glitch_q <= 8'd0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      level_q  <= level_d;
      reed_q   <= reed_d;
      moving_q <= moving_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      glitch_q <= glitch_d;
    end
  end

  assign reed         = reed_q;
  assign reed_level   = level_q;
  assign moving       = moving_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_reed_conditioner.sv
// Scoreboard bench: stimulus queues expected output events by cycle, a negedge monitor matches them.
module tb_reed_conditioner;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       reed_raw;
  logic       reed;
  logic       reed_level;
  logic       moving;
  logic [7:0] glitch_count;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   g_exp  = 0;
  int   n      = 0;
  bit   mon_en = 1'b0;
  logic prev_lvl = 1'b0;
  logic prev_mov = 1'b0;

  int  q_reed[$];
  ev_t q_lvl[$];
  ev_t q_mov[$];

  reed_conditioner #(.DEBOUNCE_CYCLES(8), .STALL_CYCLES(20)) dut (
    .clock        (clock),
    .reset        (reset),
    .reed_raw     (reed_raw),
    .reed         (reed),
    .reed_level   (reed_level),
    .moving       (moving),
    .glitch_count (glitch_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s got event want none at cycle %0d", name, cyc);
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic push_closure(input int at, input bit mov_rise);
    ev_t e;
    q_reed.push_back(at);
    e.cyc = at; e.val = 1'b1;
    q_lvl.push_back(e);
    if (mov_rise) q_mov.push_back(e);
  endtask

  task automatic push_lvl(input int at, input logic v);
    ev_t e;
    e.cyc = at; e.val = v;
    q_lvl.push_back(e);
  endtask

  task automatic push_mov(input int at, input logic v);
    ev_t e;
    e.cyc = at; e.val = v;
    q_mov.push_back(e);
  endtask

  // Monitor: every strobe and every level/moving edge must match the head of its queue.
  always @(negedge clock) begin
    ev_t e;
    int  c;
    if (mon_en) begin
      if (reed === 1'b1) begin
        if (q_reed.size() == 0) unexpected("reed_strobe");
        else begin
          c = q_reed.pop_front();
          chk("reed_cycle", cyc, c);
        end
      end
      if (reed_level !== prev_lvl) begin
        if (q_lvl.size() == 0) unexpected("level_change");
        else begin
          e = q_lvl.pop_front();
          chk("level_cycle", cyc, e.cyc);
          chk("level_value", int'(reed_level), int'(e.val));
        end
        prev_lvl = reed_level;
      end
      if (moving !== prev_mov) begin
        if (q_mov.size() == 0) unexpected("moving_change");
        else begin
          e = q_mov.pop_front();
          chk("moving_cycle", cyc, e.cyc);
          chk("moving_value", int'(moving), int'(e.val));
        end
        prev_mov = moving;
      end
    end
  end

  initial begin
    reset    = 1'b0;
    reed_raw = 1'b1;
    tick(3);
    chk("rst_reed", int'(reed), 0);
    chk("rst_level", int'(reed_level), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_glitch", int'(glitch_count), 0);

    // Release reset with the input already high.
    mon_en = 1'b1;
    reset  = 1'b1;
    n = cyc;
    push_closure(n + 10, 1'b1);
    tick(20);
    reed_raw = 1'b0;
    n = cyc;
    push_lvl(n + 10, 1'b0);
    push_mov(n + 10, 1'b0);
    tick(20);
    chk("glitch_after_reset_run", int'(glitch_count), g_exp);

    // Clean closure and release, moving falls 20 edges after the strobe.
    reed_raw = 1'b1;
    n = cyc;
    push_closure(n + 10, 1'b1);
    tick(20);
    reed_raw = 1'b0;
    n = cyc;
    push_lvl(n + 10, 1'b0);
    push_mov(n + 10, 1'b0);
    tick(20);

    // Second strobe lands exactly on the stall expiry edge.
    reed_raw = 1'b1;
    n = cyc;
    push_closure(n + 10, 1'b1);
    tick(12);
    reed_raw = 1'b0;
    push_lvl(n + 22, 1'b0);
    tick(8);
    reed_raw = 1'b1;
    push_closure(n + 30, 1'b0);
    tick(12);
    reed_raw = 1'b0;
    push_lvl(n + 42, 1'b0);
    push_mov(n + 50, 1'b0);
    tick(25);
    chk("glitch_clean_runs", int'(glitch_count), g_exp);

    // Bounce burst then a stable hold.
    repeat (3) begin
      reed_raw = 1'b1; tick(4);
      reed_raw = 1'b0; tick(4);
    end
    g_exp += 3;
    reed_raw = 1'b1;
    n = cyc;
    push_closure(n + 10, 1'b1);
    tick(12);
    chk("glitch_burst", int'(glitch_count), g_exp);
    tick(8);
    reed_raw = 1'b0;
    n = cyc;
    push_lvl(n + 10, 1'b0);
    push_mov(n + 10, 1'b0);
    tick(20);

    // Saturation: short pulses only, no strobe may appear.
    repeat (100) begin
      reed_raw = 1'b1; tick(2);
      reed_raw = 1'b0; tick(2);
    end
    tick(4);
    g_exp += 100;
    chk("glitch_mid", int'(glitch_count), g_exp);
    repeat (200) begin
      reed_raw = 1'b1; tick(2);
      reed_raw = 1'b0; tick(2);
    end
    tick(4);
    g_exp = (g_exp + 200 > 255) ? 255 : g_exp + 200;
    chk("glitch_saturated", int'(glitch_count), g_exp);
    chk("level_after_glitches", int'(reed_level), 0);

    // Reset with the debounce counter at 5 and the input held high.
    reed_raw = 1'b1;
    tick(7);
    reset = 1'b0;
    tick(2);
    g_exp = 0;
    chk("glitch_cleared_by_reset", int'(glitch_count), g_exp);
    chk("level_in_reset", int'(reed_level), 0);
    reset = 1'b1;
    n = cyc;
    push_closure(n + 10, 1'b1);
    tick(9);
    chk("no_early_strobe", int'(reed), 0);
    tick(11);
    reed_raw = 1'b0;
    n = cyc;
    push_lvl(n + 10, 1'b0);
    push_mov(n + 10, 1'b0);
    tick(15);
    chk("glitch_final", int'(glitch_count), g_exp);

    chk("reed_events_left", q_reed.size(), 0);
    chk("level_events_left", q_lvl.size(), 0);
    chk("moving_events_left", q_mov.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
